// File: rtl/srsw_fifo_pkg.sv
// Shared sizing helpers and types for the srsw FIFO controller and its
// output skid buffer.
package srsw_fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 2;

  // RAM depth for a given address width.
  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  localparam int unsigned DEF_DEPTH   = fifo_depth(DEF_ADDR_WIDTH);
  // Pointers carry one extra bit so that full and empty can be told apart.
  localparam int unsigned PTR_WIDTH   = DEF_ADDR_WIDTH + 1;
  // Occupancy reaches DEPTH + 2 (RAM plus two buffered words), hence +2 bits.
  localparam int unsigned CNT_WIDTH   = DEF_ADDR_WIDTH + 2;
  localparam int unsigned BUF_ENTRIES = 2;

  typedef logic [PTR_WIDTH-1:0] ptr_t;
  typedef logic [1:0]           bcnt_t;

endpackage

// File: rtl/srsw_skid_buf.sv
// Two-entry output buffer fed by RAM read data. Push lands at the tail, pop
// retires the head; a push and a pop in the same cycle leave the count alone.
module srsw_skid_buf
  import srsw_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output bcnt_t                 bcnt,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [DATA_WIDTH-1:0] entry0;
  logic [DATA_WIDTH-1:0] entry1;
  logic                  bhead;
  logic                  tail;
  logic                  do_pop;

  assign out_valid = (bcnt != 2'd0);
  assign do_pop    = pop & out_valid;
  // Tail sits bcnt slots past the head; with two slots only bcnt[0] matters.
  assign tail      = bhead ^ bcnt[0];
  assign out_data  = bhead ? entry1 : entry0;

  // Storage, head index and occupancy; entries are cleared so nothing stale
  // can be presented after a reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      entry0 <= '0;
      entry1 <= '0;
      bhead  <= 1'b0;
      bcnt   <= 2'd0;
    end else begin
      if (push) begin
        if (tail) entry1 <= push_data;
        else      entry0 <= push_data;
      end
      if (do_pop) bhead <= ~bhead;
      case ({push, do_pop})
        2'b10:   bcnt <= bcnt + 2'd1;
        2'b01:   bcnt <= bcnt - 2'd1;
        default: bcnt <= bcnt;
      endcase
    end
  end

endmodule

// File: rtl/srsw_fifo_ctrl.sv
// FIFO controller wrapped around an external single-read/single-write RAM with
// a one-cycle registered read. Words are prefetched from the RAM into a
// two-entry skid buffer so the output side can sustain one word per cycle.
module srsw_fifo_ctrl
  import srsw_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH+1:0] count
);

  localparam int unsigned       DEPTH   = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_P = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH + 1)'(1);

  logic [ADDR_WIDTH:0] wptr;
  logic [ADDR_WIDTH:0] rptr;
  logic [ADDR_WIDTH:0] mem_cnt;
  logic                inflight;
  bcnt_t               bcnt;
  logic                pop;
  logic [2:0]          occ_after;

  assign mem_cnt   = wptr - rptr;

  assign in_ready  = reset_n & (mem_cnt < DEPTH_P);
  assign mem_wen   = in_valid & in_ready;
  assign mem_waddr = wptr[ADDR_WIDTH-1:0];
  assign mem_wdata = in_data;

  // Buffer plus in-flight read after this cycle's pop must leave a free slot
  // for the word being requested now, so the buffer can never overflow.
  assign pop       = out_valid & out_ready;
  assign occ_after = {1'b0, bcnt} + {2'b00, inflight} - {2'b00, pop};
  assign mem_ren   = reset_n & (mem_cnt != '0) & (occ_after < 3'd2);
  assign mem_raddr = rptr[ADDR_WIDTH-1:0];

  assign count = reset_n
               ? ({1'b0, mem_cnt} + (ADDR_WIDTH + 2)'(inflight) + (ADDR_WIDTH + 2)'(bcnt))
               : '0;

  // RAM pointers advance on each accepted write / issued read; inflight marks
  // that mem_rdata carries a word this cycle. Clearing inflight on reset drops
  // any read that was already underway.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr     <= '0;
      rptr     <= '0;
      inflight <= 1'b0;
    end else begin
      if (mem_wen) wptr <= wptr + PTR_ONE;
      if (mem_ren) rptr <= rptr + PTR_ONE;
      inflight <= mem_ren;
    end
  end

  srsw_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid_buf (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (inflight),
    .push_data (mem_rdata),
    .pop       (out_ready),
    .bcnt      (bcnt),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

endmodule

// File: tb/tb_srsw_fifo_ctrl.sv
// Directed and randomised bench for srsw_fifo_ctrl with a behavioural RAM
// that returns read data one cycle after mem_ren, and a queue scoreboard.
module tb_srsw_fifo_ctrl;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        mem_wen;
  logic [1:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_ren;
  logic [1:0]  mem_raddr;
  logic [31:0] mem_rdata;
  logic [3:0]  count;

  logic [31:0] ram [0:3];
  logic [31:0] q[$];
  int          compared;
  int          mismatched;

  srsw_fifo_ctrl #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (2)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .mem_wen   (mem_wen),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_ren   (mem_ren),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .count     (count)
  );

  // Free-running 10 ns clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // External RAM: write on wen, registered read data the cycle after ren.
  always @(posedge clock) begin
    if (mem_wen) ram[mem_waddr] <= mem_wdata;
    if (mem_ren) mem_rdata <= ram[mem_raddr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, then wait for the
  // falling edge so combinational outputs are settled for sampling.
  task automatic applyStimulus(input logic iv, input logic [31:0] d, input logic ordy);
    @(posedge clock);
    #1;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(negedge clock);
  endtask

  // Scoreboard step for the current cycle: occupancy, popped data, pushes.
  task automatic track();
    checkOutput("count", 32'(count), 32'(q.size()));
    checkOutput("count_max", 32'(count <= 4'd6), 32'd1);
    if (out_valid && out_ready) begin
      if (q.size() == 0) checkOutput("pop_empty", 32'd1, 32'd0);
      else               checkOutput("out_data", out_data, q.pop_front());
    end
    if (in_valid && in_ready) q.push_back(in_data);
  endtask

  initial begin
    logic [31:0] next_val;
    bit          seen;
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b0;
    in_valid   = 1'b1;
    in_data    = 32'h1234_5678;
    out_ready  = 1'b0;

    // Reset state, with in_valid asserted to prove no write escapes.
    repeat (2) @(negedge clock);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_mem_wen", 32'(mem_wen), 32'd0);
    checkOutput("rst_mem_ren", 32'(mem_ren), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    reset_n  = 1'b1;
    in_valid = 1'b0;

    // Single word latency: write T, ren T+1, data T+2, out_valid T+3.
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1);
    checkOutput("lat_in_ready", 32'(in_ready), 32'd1);
    checkOutput("lat_wen", 32'(mem_wen), 32'd1);
    checkOutput("lat_waddr", 32'(mem_waddr), 32'd0);
    checkOutput("lat_ren0", 32'(mem_ren), 32'd0);
    track();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("lat_ren1", 32'(mem_ren), 32'd1);
    checkOutput("lat_raddr", 32'(mem_raddr), 32'd0);
    checkOutput("lat_valid1", 32'(out_valid), 32'd0);
    track();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("lat_ren2", 32'(mem_ren), 32'd0);
    checkOutput("lat_valid2", 32'(out_valid), 32'd0);
    track();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("lat_valid3", 32'(out_valid), 32'd1);
    checkOutput("lat_data3", out_data, 32'hDEAD_BEEF);
    track();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("lat_valid4", 32'(out_valid), 32'd0);
    checkOutput("lat_count4", 32'(count), 32'd0);
    track();

    // Fill with the consumer stalled: exactly six words fit.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'(i + 1), 1'b0);
      checkOutput("fill_ready", 32'(in_ready), 32'(i < 6));
      checkOutput("fill_wen", 32'(mem_wen), 32'(i < 6));
      track();
    end
    checkOutput("full_count", 32'(count), 32'd6);
    checkOutput("full_ren", 32'(mem_ren), 32'd0);
    checkOutput("full_valid", 32'(out_valid), 32'd1);
    checkOutput("full_head", out_data, 32'd1);

    // Stream from full: one word out every cycle; the write side opens one
    // cycle later once the first RAM read frees a slot.
    next_val = 32'd7;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, next_val, 1'b1);
      checkOutput("stream_valid", 32'(out_valid), 32'd1);
      checkOutput("stream_ready", 32'(in_ready), 32'(i != 0));
      if (in_ready) next_val++;
      track();
    end

    // Drain down to three held entries, then pulse reset mid-cycle.
    for (int i = 0; i < 20 && q.size() > 3; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      track();
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("pre_rst_count", 32'(count), 32'd3);
    track();
    @(posedge clock);
    #2;
    in_valid = 1'b1;
    in_data  = 32'h0BAD_0BAD;
    reset_n  = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("arst_count", 32'(count), 32'd0);
    checkOutput("arst_wen", 32'(mem_wen), 32'd0);
    checkOutput("arst_ren", 32'(mem_ren), 32'd0);
    @(negedge clock);
    #2;
    reset_n  = 1'b1;
    in_valid = 1'b0;
    q.delete();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("post_rst_valid", 32'(out_valid), 32'd0);
      track();
    end
    applyStimulus(1'b1, 32'hA5A5_A5A5, 1'b1);
    track();
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      if (out_valid) begin
        seen = 1'b1;
        checkOutput("post_rst_first", out_data, 32'hA5A5_A5A5);
      end
      track();
    end
    checkOutput("post_rst_seen", 32'(seen), 32'd1);

    // Random handshakes for 500 cycles against the queue model.
    for (int i = 0; i < 500; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      track();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/srsw_fifo_ctrl.md
Name: srsw_fifo_ctrl

Overview:
- Synchronous FIFO controller that owns an external single-read/single-write RAM (srsw_rdata-style target: wen/waddr/wdata in, ren/raddr in, rdata registered one cycle after ren).
- Sits directly upstream and downstream of that RAM:
  - drives its write and read ports;
  - consumes its rdata into a 2-entry output skid buffer;
  - exposes valid/ready streams on both sides.
- Used as an emulation target workload for pause/scan tests: all state lives in flops plus the external RAM.

Parameters:
- DATA_WIDTH, 32, width of each FIFO entry and RAM word.
- ADDR_WIDTH, 2, RAM address width; RAM depth DEPTH = 2**ADDR_WIDTH.

Ports:
- clock  input  1  sole clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  FIFO accepts the word this cycle.
- in_data  input  DATA_WIDTH  producer word.
- out_valid  output  1  out_data holds the head entry.
- out_ready  input  1  consumer takes the head this cycle.
- out_data  output  DATA_WIDTH  head entry.
- mem_wen  output  1  RAM write enable.
- mem_waddr  output  ADDR_WIDTH  RAM write address.
- mem_wdata  output  DATA_WIDTH  RAM write data.
- mem_ren  output  1  RAM read enable.
- mem_raddr  output  ADDR_WIDTH  RAM read address.
- mem_rdata  input  DATA_WIDTH  RAM read data, valid the cycle after mem_ren.
- count  output  ADDR_WIDTH+2  total entries held (RAM + in-flight + buffer), max DEPTH+2.

Behaviour:
- State:
  - wptr, rptr: ADDR_WIDTH+1 bits, wrap modulo 2*DEPTH.
  - mem_cnt = wptr - rptr.
  - inflight: 1 bit, set the cycle after mem_ren.
  - 2-entry output buffer: buf[0..1], bhead, bcnt 0..2.
- Reset (reset_n low, async): wptr=rptr=0, inflight=0, bcnt=0, bhead=0.
  - While reset_n is low: out_valid=0, in_ready=0, mem_wen=0, mem_ren=0, count=0.
  - RAM contents are not reset.
  - Reset mid-operation discards all entries; in-flight rdata is ignored.
- Write side:
  - in_ready = reset_n & (mem_cnt < DEPTH).
  - mem_wen = in_valid & in_ready; mem_waddr = wptr[ADDR_WIDTH-1:0]; mem_wdata = in_data; wptr increments on mem_wen.
- Read side (prefetch):
  - mem_ren = (mem_cnt != 0) & (bcnt + inflight + 0 < 2 after accounting for this cycle's pop), i.e. ren when bcnt + inflight - (out_valid & out_ready) < 2.
  - mem_raddr = rptr[ADDR_WIDTH-1:0]; rptr increments on mem_ren.
  - inflight <= mem_ren. When inflight=1, mem_rdata is written into the buffer tail that cycle.
- Output:
  - out_valid = (bcnt != 0); out_data = buf[bhead].
  - Pop on out_valid & out_ready: bhead toggles.
  - Simultaneous push (inflight) and pop: bcnt unchanged.
  - Buffer never overflows; the ren rule guarantees this.
- No read/write hazard: ren only addresses entries written in earlier cycles (mem_cnt from registered pointers). A write to an address equal to mem_raddr in the same cycle cannot occur unless the RAM is full, and when full in_ready=0.
- Latency: word accepted at edge T (in cycle T) on an empty FIFO ->
  - mem_ren in cycle T+1;
  - mem_rdata valid in T+2;
  - out_valid=1 in cycle T+3.
- Throughput: one word per cycle sustained on both sides once primed.
- count = mem_cnt + inflight + bcnt.
- Full: count = DEPTH+2 when the RAM is full and the buffer holds 2.
- Empty: out_valid=0, mem_ren=0.
- Pointer wrap: MSB of wptr/rptr distinguishes full from empty; mem_cnt = DEPTH means full.

Decomposition:
- Package srsw_fifo_pkg: DEPTH localparam function, pointer/count width constants, ptr_t typedef.
- One sub-module: srsw_skid_buf, the 2-entry output buffer with push/pop/bcnt.
- Pointer logic stays in the top level.

Test Plan:
- Reset, then a single write of 0xDEADBEEF at cycle 0 with out_ready=1 -> mem_ren at cycle 1 addr 0; out_valid=1 with out_data=0xDEADBEEF at cycle 3; count returns to 0 after pop.
- out_ready=0, write 0x1..0x6 back-to-back (DEPTH=4) -> in_ready drops after the 6th word, count=6, mem_ren stops once bcnt=2; further in_valid is not accepted.
- From full, out_ready=1 and in_valid=1 continuously with incrementing data -> 1 word/cycle out, order preserved, pointers wrap past 8 with no loss or duplication.
- Simultaneous pop and in-flight push with bcnt=1 -> bcnt stays 1, out_data advances to the next word the following cycle.
- reset_n pulsed low for half a cycle mid-stream with 3 entries held -> outputs go to 0 immediately (async); after release count=0, out_valid=0, stale RAM data never appears at out_data.
- Random valid/ready for 5000 ns against a queue model -> every out_data matches the model; count never exceeds 6.
